// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_buffer
// Brief    : Captures up to two commits plus one exception per cycle, and
//            serializes them into a sequence-tagged record FIFO. The FIFO is
//            drained over a valid/ready interface. Admission is all-or-nothing
//            per cycle, and a saturating counter tracks the records that were
//            dropped.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_buffer #(
    parameter int PC_W   = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [1:0]                   commit_ack_i,
    input  logic [1:0][PC_W-1:0]         commit_pc_i,
    input  logic [1:0][31:0]             commit_instr_i,
    input  logic [1:0][4:0]              commit_rd_i,
    input  logic [1:0]                   commit_we_i,
    input  logic [1:0]                   commit_fpr_i,
    input  logic [1:0][DATA_W-1:0]       commit_wdata_i,
    input  logic [1:0]                   priv_lvl_i,
    input  logic                         debug_mode_i,
    input  logic                         ex_valid_i,
    input  logic [DATA_W-1:0]            ex_cause_i,
    input  logic [PC_W-1:0]              ex_tval_i,
    output logic                         rec_valid_o,
    input  logic                         rec_ready_i,
    output logic                         rec_kind_o,
    output logic [PC_W-1:0]              rec_pc_o,
    output logic [31:0]                  rec_instr_o,
    output logic [4:0]                   rec_rd_o,
    output logic                         rec_we_o,
    output logic                         rec_fpr_o,
    output logic [DATA_W-1:0]            rec_data_o,
    output logic [PC_W-1:0]              rec_tval_o,
    output logic [1:0]                   rec_priv_o,
    output logic                         rec_dbg_o,
    output logic [15:0]                  rec_seq_o,
    output logic [15:0]                  drop_cnt_o,
    output logic [$clog2(DEPTH):0]       level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic              kind;
        logic [PC_W-1:0]   pc;
        logic [31:0]       instr;
        logic [4:0]        rd;
        logic              we;
        logic              fpr;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   tval;
        logic [1:0]        priv;
        logic              dbg;
        logic [15:0]       seq;
    } rec_t;

    rec_t             mem_q [DEPTH];
    rec_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [15:0]      seq_q, seq_d;
    logic [15:0]      drop_q, drop_d;

    rec_t             cand [3];
    logic [2:0]       cand_act;
    logic [1:0]       cand_idx [3];
    logic [1:0]       n_act;
    logic [LVL_W-1:0] free_slots;
    logic             admit;
    logic             drop;
    logic             pop;
    logic [16:0]      drop_sum;
    rec_t             head;

    // Build the three candidate records in the fixed order C0, C1, CE.
    // Also compute each candidate's slot offset within this cycle's burst.
    always_comb begin
        cand_act[0] = commit_ack_i[0];
        cand_act[1] = commit_ack_i[1];
        // Debug-mode breakpoints (cause 3) are part of debug entry, not trace.
        cand_act[2] = ex_valid_i && !(debug_mode_i && (ex_cause_i == DATA_W'(3)));

        cand_idx[0] = 2'd0;
        cand_idx[1] = {1'b0, cand_act[0]};
        cand_idx[2] = {1'b0, cand_act[0]} + {1'b0, cand_act[1]};
        n_act       = cand_idx[2] + {1'b0, cand_act[2]};

        for (int p = 0; p < 2; p++) begin
            cand[p]       = '0;
            cand[p].kind  = 1'b0;
            cand[p].pc    = commit_pc_i[p];
            cand[p].instr = commit_instr_i[p];
            cand[p].rd    = commit_rd_i[p];
            cand[p].we    = commit_we_i[p];
            cand[p].fpr   = commit_fpr_i[p];
            cand[p].data  = commit_wdata_i[p];
            cand[p].priv  = priv_lvl_i;
            cand[p].dbg   = debug_mode_i;
        end

        // Exception records borrow port 0's PC and carry cause/tval.
        cand[2]      = '0;
        cand[2].kind = 1'b1;
        cand[2].pc   = commit_pc_i[0];
        cand[2].data = ex_cause_i;
        cand[2].tval = ex_tval_i;
        cand[2].priv = priv_lvl_i;
        cand[2].dbg  = debug_mode_i;

        for (int c = 0; c < 3; c++) begin
            cand[c].seq = seq_q + 16'(cand_idx[c]);
        end
    end

    // Admission decision against the registered occupancy (same-cycle pop not credited).
    always_comb begin
        free_slots = LVL_W'(DEPTH) - level_q;
        admit      = enable_i && (n_act != 2'd0) && (LVL_W'(n_act) <= free_slots);
        drop       = enable_i && (LVL_W'(n_act) > free_slots);
        pop        = (level_q != '0) && rec_ready_i;
    end

    // Next-state for pointers, occupancy, sequence and drop counters.
    always_comb begin
        wr_ptr_d = admit ? (wr_ptr_q + PTR_W'(n_act)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        level_d  = level_q + (admit ? LVL_W'(n_act) : LVL_W'(0))
                           - (pop ? LVL_W'(1) : LVL_W'(0));
        seq_d    = enable_i ? (seq_q + 16'(n_act)) : seq_q;
        drop_sum = {1'b0, drop_q} + 17'(n_act);
        drop_d   = drop_q;
        if (drop) begin
            drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Storage write: active candidates land in consecutive slots from wr_ptr.
    always_comb begin
        mem_d = mem_q;
        if (admit) begin
            for (int c = 0; c < 3; c++) begin
                if (cand_act[c]) begin
                    mem_d[wr_ptr_q + PTR_W'(cand_idx[c])] = cand[c];
                end
            end
        end
    end

    // State registers with synchronous reset that also scrubs storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    // Head record; all outputs are forced to zero while reset is held.
    always_comb begin
        head = rst_i ? '0 : mem_q[rd_ptr_q];
    end

    assign rec_valid_o = !rst_i && (level_q != '0);
    assign rec_kind_o  = head.kind;
    assign rec_pc_o    = head.pc;
    assign rec_instr_o = head.instr;
    assign rec_rd_o    = head.rd;
    assign rec_we_o    = head.we;
    assign rec_fpr_o   = head.fpr;
    assign rec_data_o  = head.data;
    assign rec_tval_o  = head.tval;
    assign rec_priv_o  = head.priv;
    assign rec_dbg_o   = head.dbg;
    assign rec_seq_o   = head.seq;
    assign drop_cnt_o  = rst_i ? 16'd0 : drop_q;
    assign level_o     = rst_i ? '0 : level_q;

endmodule
`default_nettype wire

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable capture stage between the commit stage and a trace sink: simulation tracer, debug trace port or off-chip trace encoder.
- Samples both commit ports plus the commit exception each cycle and serializes them into an ordered record stream.
- Buffers records in a FIFO and presents them on a valid/ready interface.
- Tags each record with a sequence number and counts records lost on overflow, so the sink can detect gaps.

Parameters:
- PC_W, 64, width of PC and tval fields
- DATA_W, 64, width of write-back data and exception cause
- DEPTH, 8, FIFO entries; power of two, at least 4

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  capture enable; when 0, nothing is enqueued and nothing is counted as dropped
- commit_ack_i  in  2  per-port commit acknowledge
- commit_pc_i  in  2xPC_W  per-port PC
- commit_instr_i  in  2x32  per-port instruction word
- commit_rd_i  in  2x5  per-port destination register
- commit_we_i  in  2  per-port register write enable (GPR or FPR)
- commit_fpr_i  in  2  per-port: destination is an FPR
- commit_wdata_i  in  2xDATA_W  per-port write-back data
- priv_lvl_i  in  2  current privilege level
- debug_mode_i  in  1  hart is in debug mode
- ex_valid_i  in  1  commit exception valid
- ex_cause_i  in  DATA_W  exception cause
- ex_tval_i  in  PC_W  exception tval
- rec_valid_o  out  1  FIFO head is valid
- rec_ready_i  in  1  sink accepts the head record
- rec_kind_o  out  1  record kind: 0 = instruction, 1 = exception
- rec_pc_o  out  PC_W  record PC
- rec_instr_o  out  32  instruction word; 0 for exception records
- rec_rd_o  out  5  destination register; 0 for exception records
- rec_we_o  out  1  write flag
- rec_fpr_o  out  1  FPR flag
- rec_data_o  out  DATA_W  wdata for instruction records, cause for exception records
- rec_tval_o  out  PC_W  tval for exception records; 0 otherwise
- rec_priv_o  out  2  privilege level at capture
- rec_dbg_o  out  1  debug mode at capture
- rec_seq_o  out  16  record sequence number
- drop_cnt_o  out  16  dropped-record count, saturating
- level_o  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk_i.
  - rst_i=1 clears pointers, occupancy, seq counter, drop counter and all storage entries.
  - Every output reads 0 while rst_i=1 and on the first cycle after it deasserts.
  - Reset mid-stream discards all buffered records.
- Candidates per cycle, in this fixed order:
  - C0: commit_ack_i[0].
  - C1: commit_ack_i[1]. Valid even when ack[0]=0.
  - CE: ex_valid_i && !(debug_mode_i && ex_cause_i==3). Debug breakpoints are suppressed.
  - CE takes its pc from commit_pc_i[0].
  - N = number of active candidates, 0..3.
  - priv_lvl_i and debug_mode_i are sampled into every record of that cycle.
- Admission is all-or-nothing per cycle:
  - free = DEPTH - level. The registered level is used; a same-cycle dequeue does not count.
  - If enable_i && N>0 && N<=free: write N consecutive entries in order C0, C1, CE.
  - If enable_i && N>free: write nothing; drop_cnt += N, saturating at 0xFFFF.
- Sequence numbers:
  - The seq register advances by N on every enabled cycle, admitted or dropped, wrapping mod 2^16.
  - The k-th written record (k = 0..N-1) gets seq+k, so a gap in the sequence marks dropped records.
- Latency: a record written at edge t appears at the head no earlier than cycle t+1. There is no bypass.
- Output handshake:
  - The head is popped at an edge where rec_valid_o && rec_ready_i.
  - Record fields are a read of storage at the read pointer.
  - Fields hold stable while rec_valid_o=1 && rec_ready_i=0.
- Simultaneous push and pop:
  - Both occur in the same cycle.
  - level_next = level + written - popped.
- Pointers wrap modulo DEPTH. Full is level==DEPTH; empty is level==0, which implies rec_valid_o=0.
- enable_i changes take effect on the same cycle and do not affect entries already buffered.

Test Plan:
- Reset, then a single commit with ack=01, pc=0x80000000, instr=0x00100093, rd=1, we=1, wdata=1 -> the next cycle rec_valid=1, kind=0, seq=0, data=1, level=1; ready=1 pops it and level=0.
- Dual commit ack=11 plus ex_valid with cause=2, tval=0xdeadbeef -> three records in order port0, port1, exception; seq 0, 1, 2; the exception record has pc=commit_pc_i[0], data=2.
- debug_mode=1, ex_valid, cause=3 -> no record and seq unchanged. Same stimulus with debug_mode=0 -> one exception record.
- Hold ready=0 with DEPTH=8 and fill to level=7, then apply ack=11 -> drop_cnt=2, level=7, seq advances by 2. The next admitted record's seq shows the gap of 2.
- Level=8 with ready=1 and ack=01 in the same cycle -> the record is dropped (registered level is used) and level ends at 7. Stream 20 single commits with ready=1 -> pointers wrap and every seq is contiguous.
- Force drop_cnt to 0xFFFE, then overflow by 3 -> drop_cnt=0xFFFF and stays there. Start the seq counter at 0xFFFE and admit 3 records -> seq 0xFFFE, 0xFFFF, 0x0000. Assert rst_i mid-stream -> the next cycle all outputs read 0.
